// File: rtl/uart_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the 8250 UART register slave; ERR on unACKed timeout.
// Latency: request -> S_CYC_O one cycle; ACK/read data pass through combinationally.
// Backpressure: a granted tenure is never pre-empted, the other master stalls until CYC drops.
module uart_wb_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8,
    parameter int RR      = 1
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] M0_ADR_I,
    input  logic [31:0] M0_DAT_I,
    output logic [31:0] M0_DAT_O,
    input  logic        M0_WE_I,
    input  logic [3:0]  M0_SEL_I,
    input  logic        M0_STB_I,
    input  logic        M0_CYC_I,
    output logic        M0_ACK_O,
    output logic        M0_ERR_O,
    input  logic [31:0] M1_ADR_I,
    input  logic [31:0] M1_DAT_I,
    output logic [31:0] M1_DAT_O,
    input  logic        M1_WE_I,
    input  logic [3:0]  M1_SEL_I,
    input  logic        M1_STB_I,
    input  logic        M1_CYC_I,
    output logic        M1_ACK_O,
    output logic        M1_ERR_O,
    output logic [31:0] S_ADR_O,
    output logic [31:0] S_DAT_O,
    input  logic [31:0] S_DAT_I,
    output logic        S_WE_O,
    output logic [3:0]  S_SEL_O,
    output logic        S_STB_O,
    output logic        S_CYC_O,
    input  logic        S_ACK_I,
    output logic [1:0]  GNT_O
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ERR} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_gnt;
    logic              r_ptr;
    logic [TO_W-1:0]   r_cnt;

    logic w_gcyc;
    logic w_gstb;
    logic w_pick1;
    logic w_timeout;
    logic w_stall;
    logic w_busy;

    assign w_gcyc    = r_gnt[1] ? M1_CYC_I : (r_gnt[0] & M0_CYC_I);
    assign w_gstb    = r_gnt[1] ? M1_STB_I : (r_gnt[0] & M0_STB_I);
    // r_ptr=1 means master 1 held the bus last, so master 0 wins a tie
    assign w_pick1   = M1_CYC_I & (~M0_CYC_I | ((RR != 0) & ~r_ptr));
    assign w_timeout = (r_cnt == TO_W'(TIMEOUT - 1));
    assign w_busy    = (r_state == ST_BUSY);
    assign w_stall   = w_busy & w_gstb & ~S_ACK_I;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (M0_CYC_I | M1_CYC_I) w_next = ST_BUSY;
            ST_BUSY: begin
                if (!w_gcyc)                  w_next = ST_IDLE;
                else if (w_stall && w_timeout) w_next = ST_ERR;
            end
            ST_ERR:  w_next = w_gcyc ? ST_BUSY : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_gnt <= 2'b00;
            r_ptr <= 1'b1;
            r_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE && w_next == ST_BUSY) begin
                r_gnt <= {w_pick1, ~w_pick1};
            end else if (r_state != ST_IDLE && w_next == ST_IDLE) begin
                r_ptr <= r_gnt[1];
                r_gnt <= 2'b00;
            end
            if (w_stall && !w_timeout) r_cnt <= r_cnt + TO_W'(1);
            else                       r_cnt <= '0;
        end
    end

    always_comb begin
        S_ADR_O  = 32'h0;
        S_DAT_O  = 32'h0;
        S_WE_O   = 1'b0;
        S_SEL_O  = 4'h0;
        S_STB_O  = 1'b0;
        S_CYC_O  = 1'b0;
        M0_DAT_O = 32'h0;
        M1_DAT_O = 32'h0;
        M0_ACK_O = 1'b0;
        M1_ACK_O = 1'b0;
        M0_ERR_O = (r_state == ST_ERR) & r_gnt[0];
        M1_ERR_O = (r_state == ST_ERR) & r_gnt[1];
        GNT_O    = r_gnt;
        if (w_busy) begin
            S_ADR_O = r_gnt[1] ? M1_ADR_I : M0_ADR_I;
            S_DAT_O = r_gnt[1] ? M1_DAT_I : M0_DAT_I;
            S_WE_O  = r_gnt[1] ? M1_WE_I  : M0_WE_I;
            S_SEL_O = r_gnt[1] ? M1_SEL_I : M0_SEL_I;
            S_STB_O = w_gstb;
            S_CYC_O = w_gcyc;
            if (r_gnt[0]) begin
                M0_DAT_O = S_DAT_I;
                M0_ACK_O = S_ACK_I & w_gstb;
            end
            if (r_gnt[1]) begin
                M1_DAT_O = S_DAT_I;
                M1_ACK_O = S_ACK_I & w_gstb;
            end
        end
    end

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Scoreboard bench for uart_wb_arbiter: round-robin instance plus a fixed-priority twin.
module tb_uart_wb_arbiter;

    localparam logic [31:0] BASE = 32'h9000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic        m_we  [2];
    logic        m_stb [2];
    logic        m_cyc [2];
    logic [31:0] s_dat_i;
    logic        s_ack_i;

    wire [31:0] m0_dat, m1_dat, s_adr, s_dato;
    wire        m0_ack, m0_err, m1_ack, m1_err, s_we, s_stb, s_cyc;
    wire [3:0]  s_sel;
    wire [1:0]  gnt;

    wire [31:0] fp_m0_dat, fp_m1_dat, fp_s_adr, fp_s_dato;
    wire        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err, fp_s_we, fp_s_stb, fp_s_cyc;
    wire [3:0]  fp_s_sel;
    wire [1:0]  fp_gnt;

    int checks = 0;
    int failures = 0;
    logic [31:0] rq [$];
    typedef struct packed {logic [31:0] adr; logic [31:0] dat; logic [3:0] sel;} wr_t;
    wr_t wq [$];

    uart_wb_arbiter #(.TIMEOUT(16), .TO_W(8), .RR(1)) dut (
        .CLK_I(clk), .RST_I(rst_n),
        .M0_ADR_I(m_adr[0]), .M0_DAT_I(m_dat[0]), .M0_DAT_O(m0_dat), .M0_WE_I(m_we[0]),
        .M0_SEL_I(m_sel[0]), .M0_STB_I(m_stb[0]), .M0_CYC_I(m_cyc[0]), .M0_ACK_O(m0_ack), .M0_ERR_O(m0_err),
        .M1_ADR_I(m_adr[1]), .M1_DAT_I(m_dat[1]), .M1_DAT_O(m1_dat), .M1_WE_I(m_we[1]),
        .M1_SEL_I(m_sel[1]), .M1_STB_I(m_stb[1]), .M1_CYC_I(m_cyc[1]), .M1_ACK_O(m1_ack), .M1_ERR_O(m1_err),
        .S_ADR_O(s_adr), .S_DAT_O(s_dato), .S_DAT_I(s_dat_i), .S_WE_O(s_we), .S_SEL_O(s_sel),
        .S_STB_O(s_stb), .S_CYC_O(s_cyc), .S_ACK_I(s_ack_i), .GNT_O(gnt)
    );

    uart_wb_arbiter #(.TIMEOUT(16), .TO_W(8), .RR(0)) dut_fp (
        .CLK_I(clk), .RST_I(rst_n),
        .M0_ADR_I(m_adr[0]), .M0_DAT_I(m_dat[0]), .M0_DAT_O(fp_m0_dat), .M0_WE_I(m_we[0]),
        .M0_SEL_I(m_sel[0]), .M0_STB_I(m_stb[0]), .M0_CYC_I(m_cyc[0]), .M0_ACK_O(fp_m0_ack), .M0_ERR_O(fp_m0_err),
        .M1_ADR_I(m_adr[1]), .M1_DAT_I(m_dat[1]), .M1_DAT_O(fp_m1_dat), .M1_WE_I(m_we[1]),
        .M1_SEL_I(m_sel[1]), .M1_STB_I(m_stb[1]), .M1_CYC_I(m_cyc[1]), .M1_ACK_O(fp_m1_ack), .M1_ERR_O(fp_m1_err),
        .S_ADR_O(fp_s_adr), .S_DAT_O(fp_s_dato), .S_DAT_I(s_dat_i), .S_WE_O(fp_s_we), .S_SEL_O(fp_s_sel),
        .S_STB_O(fp_s_stb), .S_CYC_O(fp_s_cyc), .S_ACK_I(s_ack_i), .GNT_O(fp_gnt)
    );

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return 32'h5A00_0000 ^ a;
    endfunction

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        m_cyc[m] = cyc; m_stb[m] = stb; m_we[m] = we;
        m_adr[m] = adr; m_dat[m] = dat; m_sel[m] = sel;
    endtask

    task automatic idle_all();
        set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        set_m(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        s_ack_i = 1'b0;
        s_dat_i = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_all();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Returns at the negedge of the first cycle where GNT_O equals g, or after the budget
    task automatic wait_grant(input logic [1:0] g, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (gnt === g) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_m(0, 1, 1, 0, BASE, 32'h0, 4'hF);
        s_ack_i = 1'b1;
        s_dat_i = 32'hDEAD_BEEF;
        #2;
        checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        checks++; if ({s_cyc, s_stb} !== 2'b00) begin failures++; $display("FAIL reset_slave: cyc/stb got %b want 00", {s_cyc, s_stb}); end
        checks++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin failures++; $display("FAIL reset_ackerr: got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
        checks++; if (m0_dat !== 32'h0) begin failures++; $display("FAIL reset_dat: got %h want 0", m0_dat); end
        do_reset();
    endtask

    task automatic test_single_read();
        logic [31:0] exp;
        do_reset();
        set_m(0, 1, 1, 0, BASE + 5, 32'h0, 4'hF);
        rq.push_back(rd_of(BASE + 5));
        @(negedge clk);
        checks++; if (s_cyc !== 1'b0) begin failures++; $display("FAIL rd_lat0: s_cyc got %b want 0", s_cyc); end
        tick();
        @(negedge clk);
        checks++; if ({s_cyc, gnt} !== 3'b101) begin failures++; $display("FAIL rd_lat1: cyc,gnt got %b want 101", {s_cyc, gnt}); end
        checks++; if (s_adr !== BASE + 5 || s_we !== 1'b0) begin failures++; $display("FAIL rd_adr: got %h we=%b want %h", s_adr, s_we, BASE + 5); end
        s_dat_i = rd_of(s_adr);
        s_ack_i = 1'b1;
        #1;
        checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL rd_ack: got %b want 1", m0_ack); end
        exp = (rq.size() != 0) ? rq.pop_front() : 32'hX;
        checks++; if (m0_dat !== exp) begin failures++; $display("FAIL rd_dat: got %h want %h", m0_dat, exp); end
        checks++; if ({m1_ack, m1_err, m1_dat} !== 34'h0) begin failures++; $display("FAIL rd_m1_quiet: ack=%b err=%b dat=%h want 0", m1_ack, m1_err, m1_dat); end
        tick();
        idle_all();
        repeat (3) tick();
    endtask

    task automatic test_rr();
        do_reset();
        set_m(0, 1, 0, 0, BASE, 32'h0, 4'hF);
        set_m(1, 1, 0, 0, BASE + 1, 32'h0, 4'hF);
        @(negedge clk);
        checks++; if ({gnt, fp_gnt} !== 4'b0000) begin failures++; $display("FAIL rr_idle: rr=%b fp=%b want 00/00", gnt, fp_gnt); end
        tick(); @(negedge clk);
        checks++; if ({gnt, fp_gnt} !== 4'b0101) begin failures++; $display("FAIL rr_first: rr=%b fp=%b want 01/01", gnt, fp_gnt); end
        tick(); m_cyc[0] = 1'b0;
        @(negedge clk);
        tick(); m_cyc[0] = 1'b1;
        @(negedge clk);
        checks++; if ({gnt, fp_gnt} !== 4'b0000) begin failures++; $display("FAIL rr_gap: rr=%b fp=%b want 00/00", gnt, fp_gnt); end
        tick(); @(negedge clk);
        checks++; if ({gnt, fp_gnt} !== 4'b1001) begin failures++; $display("FAIL rr_second: rr=%b fp=%b want 10/01", gnt, fp_gnt); end
        tick(); @(negedge clk);
        checks++; if ({gnt, fp_gnt} !== 4'b1001) begin failures++; $display("FAIL rr_hold: rr=%b fp=%b want 10/01", gnt, fp_gnt); end
        tick(); m_cyc[1] = 1'b0;
        @(negedge clk);
        tick(); @(negedge clk);
        checks++; if ({gnt, fp_gnt} !== 4'b0001) begin failures++; $display("FAIL rr_release: rr=%b fp=%b want 00/01", gnt, fp_gnt); end
        tick(); @(negedge clk);
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL rr_third: rr=%b want 01", gnt); end
        tick();
        idle_all();
        repeat (3) tick();
    endtask

    task automatic test_write_stall();
        int n;
        bit ok;
        bit bad;
        wr_t w;
        logic [31:0] exp;
        do_reset();
        set_m(1, 1, 1, 1, BASE, 32'h41, 4'b0001);
        wq.push_back('{adr: BASE, dat: 32'h41, sel: 4'b0001});
        tick();
        set_m(0, 1, 1, 0, BASE + 1, 32'h0, 4'hF);
        rq.push_back(rd_of(BASE + 1));
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (gnt !== 2'b10 || s_dato !== 32'h41 || s_sel !== 4'b0001 || m0_ack !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++; if (bad) begin failures++; $display("FAIL wr_stall: gnt=%b dat=%h sel=%b m0_ack=%b want 10/41/0001/0", gnt, s_dato, s_sel, m0_ack); end
        @(negedge clk);
        s_dat_i = 32'h0;
        s_ack_i = 1'b1;
        #1;
        w = (wq.size() != 0) ? wq.pop_front() : '0;
        checks++; if ({s_adr, s_dato, s_sel, s_we} !== {w.adr, w.dat, w.sel, 1'b1}) begin failures++; $display("FAIL wr_bus: got %h/%h/%b we=%b want %h/%h/%b", s_adr, s_dato, s_sel, s_we, w.adr, w.dat, w.sel); end
        checks++; if ({m1_ack, m0_ack} !== 2'b10) begin failures++; $display("FAIL wr_ack: m1/m0 got %b want 10", {m1_ack, m0_ack}); end
        tick();
        s_ack_i = 1'b0;
        set_m(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
        wait_grant(2'b01, n, ok);
        checks++; if (!ok || n != 3) begin failures++; $display("FAIL wr_handover: ok=%0d cycles=%0d want 1/3", ok, n); end
        s_dat_i = rd_of(s_adr);
        s_ack_i = 1'b1;
        #1;
        exp = (rq.size() != 0) ? rq.pop_front() : 32'hX;
        checks++; if (m0_ack !== 1'b1 || m0_dat !== exp) begin failures++; $display("FAIL wr_m0_read: ack=%b dat=%h want 1/%h", m0_ack, m0_dat, exp); end
        tick();
        idle_all();
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        int errc;
        int nerr;
        logic err_stb, err_cyc, post_cyc;
        logic [31:0] exp;
        do_reset();
        set_m(0, 1, 1, 0, BASE + 2, 32'h0, 4'hF);
        wait_grant(2'b01, n, ok);
        errc = 0; nerr = 0; err_stb = 1'bx; err_cyc = 1'bx; post_cyc = 1'bx;
        for (int c = 1; c <= 24; c++) begin
            if (c > 1) @(negedge clk);
            if (m0_err === 1'b1) begin
                nerr++;
                if (errc == 0) begin errc = c; err_stb = s_stb; err_cyc = s_cyc; end
            end
            if (errc != 0 && c == errc + 1) post_cyc = s_cyc;
            tick();
            if (errc != 0) m_stb[0] = 1'b0;
        end
        checks++; if (!ok || errc != 17) begin failures++; $display("FAIL to_when: err at busy cycle %0d want 17", errc); end
        checks++; if (nerr != 1) begin failures++; $display("FAIL to_pulse: err cycles %0d want 1", nerr); end
        checks++; if ({err_stb, err_cyc} !== 2'b00) begin failures++; $display("FAIL to_slave: stb/cyc in err got %b want 00", {err_stb, err_cyc}); end
        checks++; if (post_cyc !== 1'b1) begin failures++; $display("FAIL to_resume: s_cyc after err got %b want 1", post_cyc); end
        idle_all();
        repeat (2) tick();
        set_m(0, 1, 1, 0, BASE + 6, 32'h0, 4'hF);
        rq.push_back(rd_of(BASE + 6));
        wait_grant(2'b01, n, ok);
        for (int c = 1; c < 16; c++) begin
            tick();
            @(negedge clk);
        end
        s_dat_i = rd_of(s_adr);
        s_ack_i = 1'b1;
        #1;
        exp = (rq.size() != 0) ? rq.pop_front() : 32'hX;
        checks++; if ({m0_ack, m0_err} !== 2'b10 || m0_dat !== exp) begin failures++; $display("FAIL to_ack_wins: ack=%b err=%b dat=%h want 1/0/%h", m0_ack, m0_err, m0_dat, exp); end
        tick();
        s_ack_i = 1'b0;
        @(negedge clk);
        checks++; if ({m0_err, s_stb} !== 2'b01) begin failures++; $display("FAIL to_no_err: err=%b stb=%b want 0/1", m0_err, s_stb); end
        tick();
        idle_all();
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_m(0, 1, 0, 0, BASE, 32'h0, 4'hF);
        set_m(1, 1, 1, 0, BASE + 3, 32'h0, 4'hF);
        tick();
        m_cyc[0] = 1'b0;
        repeat (2) tick();
        m_cyc[0] = 1'b1;
        @(negedge clk);
        checks++; if ({gnt, s_cyc} !== 3'b101) begin failures++; $display("FAIL rst_pre: gnt,cyc got %b want 101", {gnt, s_cyc}); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({gnt, s_cyc, s_stb} !== 4'b0000) begin failures++; $display("FAIL rst_async: gnt,cyc,stb got %b want 0000", {gnt, s_cyc, s_stb}); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        tick(); @(negedge clk);
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL rst_ptr: first grant got %b want 01", gnt); end
        tick();
        idle_all();
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] glog [$];
        logic [1:0] comp [$];
        int nacks, nerrs, zeros;
        bit ok;
        logic [31:0] exp;
        do_reset();
        nacks = 0; nerrs = 0;
        for (int t = 0; t < 2; t++) begin
            set_m(0, 1, 1, 0, BASE + 3 + t, 32'h0, 4'hF);
            rq.push_back(rd_of(BASE + 3 + t));
            ok = 1'b0;
            for (int k = 0; k < 10 && !ok; k++) begin
                @(negedge clk);
                glog.push_back(gnt);
                if (m0_err === 1'b1) nerrs++;
                if (gnt === 2'b01 && s_stb === 1'b1) ok = 1'b1;
                else tick();
            end
            s_dat_i = rd_of(s_adr);
            s_ack_i = 1'b1;
            #1;
            exp = (rq.size() != 0) ? rq.pop_front() : 32'hX;
            if (m0_ack === 1'b1 && m0_dat === exp) nacks++;
            tick();
            s_ack_i = 1'b0;
            set_m(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
            @(negedge clk);
            glog.push_back(gnt);
            if (m0_err === 1'b1) nerrs++;
            tick();
        end
        zeros = 0;
        foreach (glog[i]) begin
            if (comp.size() == 0 ? glog[i] != 2'b00 : glog[i] != comp[comp.size() - 1]) comp.push_back(glog[i]);
            if (comp.size() == 2 && glog[i] == 2'b00) zeros++;
        end
        checks++; if (comp.size() != 3 || comp[0] !== 2'b01 || comp[1] !== 2'b00 || comp[2] !== 2'b01) begin failures++; $display("FAIL b2b_seq: %0d distinct grant phases, want 01,00,01", comp.size()); end
        checks++; if (zeros != 1) begin failures++; $display("FAIL b2b_gap: idle cycles %0d want 1", zeros); end
        checks++; if (nacks != 2 || nerrs != 0) begin failures++; $display("FAIL b2b_acks: acks=%0d errs=%0d want 2/0", nacks, nerrs); end
        idle_all();
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_all();
        repeat (3) @(posedge clk);
        test_reset();
        test_single_read();
        test_rr();
        test_write_stall();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        checks++; if (rq.size() != 0 || wq.size() != 0) begin failures++; $display("FAIL scoreboard_drain: rq=%0d wq=%0d want 0/0", rq.size(), wq.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
